multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// driving datapath strobes and mux selects combinationally from the current state.
module multicycle_ctrl #(
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_wen,
    output logic                pc_wen,
    output logic [1:0]          npc_sel,
    output logic                RegWrite,
    output logic                Memwrite,
    output logic                MemRead,
    output logic                ALUsrc_mux,
    output logic                Write_reg_mux,
    output logic                RegDst,
    output logic                extend_op,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          state,
    output logic                illegal
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_LUI = ALU_OP_W'(5);

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;

    // Instruction classification; opcode/funct are held stable by the datapath.
    logic w_is_rtype, w_rtype_ok, w_is_addiu, w_is_ori, w_is_lui;
    logic w_is_lw, w_is_sw, w_is_beq, w_is_j, w_supported;
    logic [ALU_OP_W-1:0] w_r_alu_op;

    assign w_is_rtype  = (opcode == 6'b000000);
    assign w_is_addiu  = (opcode == 6'b001001);
    assign w_is_ori    = (opcode == 6'b001101);
    assign w_is_lui    = (opcode == 6'b001111);
    assign w_is_lw     = (opcode == 6'b100011);
    assign w_is_sw     = (opcode == 6'b101011);
    assign w_is_beq    = (opcode == 6'b000100);
    assign w_is_j      = (opcode == 6'b000010);

    always_comb begin
        w_rtype_ok = 1'b1;
        w_r_alu_op = ALU_ADD;
        case (funct)
            6'b100001: w_r_alu_op = ALU_ADD;
            6'b100011: w_r_alu_op = ALU_SUB;
            6'b100100: w_r_alu_op = ALU_AND;
            6'b100101: w_r_alu_op = ALU_OR;
            6'b101010: w_r_alu_op = ALU_SLT;
            default:   w_rtype_ok = 1'b0;
        endcase
    end

    assign w_supported = (w_is_rtype && w_rtype_ok) || w_is_addiu || w_is_ori || w_is_lui
                       || w_is_lw || w_is_sw || w_is_beq || w_is_j;

    // ALU controls chosen in EXEC and held unchanged through MEM and WB.
    logic                w_alusrc;
    logic                w_ext;
    logic [ALU_OP_W-1:0] w_alu_op;

    always_comb begin
        w_alusrc = 1'b0;
        w_ext    = 1'b0;
        w_alu_op = ALU_ADD;
        if (w_is_rtype) begin
            w_alu_op = w_r_alu_op;
        end else if (w_is_addiu) begin
            w_alusrc = 1'b1;
            w_ext    = 1'b1;
        end else if (w_is_ori) begin
            w_alusrc = 1'b1;
            w_alu_op = ALU_OR;
        end else if (w_is_lui) begin
            w_alusrc = 1'b1;
            w_alu_op = ALU_LUI;
        end else if (w_is_lw || w_is_sw) begin
            w_alusrc = 1'b1;
            w_ext    = 1'b1;
        end else if (w_is_beq) begin
            w_ext    = 1'b1;
            w_alu_op = ALU_SUB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sticky: only reset clears it, matching the HALT trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == S_HALT) begin
            r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_is_j) begin
                    w_next_state = S_FETCH;
                end else if (w_supported) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            S_EXEC: begin
                if (w_is_lw || w_is_sw) begin
                    w_next_state = S_MEM;
                end else if (w_is_beq) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_ready) begin
                    w_next_state = S_MEM;
                end else if (w_is_lw) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        ir_wen        = 1'b0;
        pc_wen        = 1'b0;
        npc_sel       = NPC_SEQ;
        RegWrite      = 1'b0;
        Memwrite      = 1'b0;
        MemRead       = 1'b0;
        ALUsrc_mux    = 1'b0;
        Write_reg_mux = 1'b0;
        RegDst        = 1'b0;
        extend_op     = 1'b0;
        alu_op        = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ir_wen = 1'b1;
                pc_wen = 1'b1;
            end
            S_DECODE: begin
                if (w_is_j) begin
                    pc_wen  = 1'b1;
                    npc_sel = NPC_JUMP;
                end
            end
            S_EXEC: begin
                ALUsrc_mux = w_alusrc;
                extend_op  = w_ext;
                alu_op     = w_alu_op;
                if (w_is_beq) begin
                    pc_wen  = zero;
                    npc_sel = NPC_BRANCH;
                end
            end
            S_MEM: begin
                ALUsrc_mux = w_alusrc;
                extend_op  = w_ext;
                alu_op     = w_alu_op;
                MemRead    = w_is_lw;
                Memwrite   = w_is_sw;
            end
            S_WB: begin
                ALUsrc_mux    = w_alusrc;
                extend_op     = w_ext;
                alu_op        = w_alu_op;
                RegWrite      = 1'b1;
                RegDst        = w_is_rtype;
                Write_reg_mux = w_is_lw;
            end
            default: ;
        endcase
        // Write strobes must drop the instant reset asserts, not at the next edge.
        if (!rst) begin
            ir_wen   = 1'b0;
            pc_wen   = 1'b0;
            RegWrite = 1'b0;
            Memwrite = 1'b0;
            MemRead  = 1'b0;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table vectors, randomized instructions against a
// per-instruction cost model, and hand-written reset/HALT/stall sequences.
module tb_multicycle_ctrl;

    localparam int unsigned ALU_OP_W = 3;

    logic                clk;
    logic                rst;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                ir_wen;
    logic                pc_wen;
    logic [1:0]          npc_sel;
    logic                RegWrite;
    logic                Memwrite;
    logic                MemRead;
    logic                ALUsrc_mux;
    logic                Write_reg_mux;
    logic                RegDst;
    logic                extend_op;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          state;
    logic                illegal;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.ALU_OP_W(ALU_OP_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ir_wen(ir_wen), .pc_wen(pc_wen), .npc_sel(npc_sel),
        .RegWrite(RegWrite), .Memwrite(Memwrite), .MemRead(MemRead),
        .ALUsrc_mux(ALUsrc_mux), .Write_reg_mux(Write_reg_mux), .RegDst(RegDst),
        .extend_op(extend_op), .alu_op(alu_op), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instruction summary: cycle count and how often each strobe fired.
    typedef struct {
        logic [5:0] opc;
        logic [5:0] fun;
        logic       z;
        int         stalls;
        int         cyc;
        int         alu;
        int         rw;
        int         rdst;
        int         wrm;
        int         pcw;
        int         npc;
        int         mrd;
        int         mwr;
    } vec_t;

    typedef struct {
        int cyc, alu, rw, rdst, wrm, pcw, npc, mrd, mwr, irw, held_bad;
    } obs_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one instruction starting at a negedge in FETCH; ends at a negedge.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fun, input logic z,
                             input int stalls, output obs_t o);
        int left;
        left = stalls;
        o = '{default: 0};
        o.alu = 7;
        o.npc = 3;
        opcode = opc;
        funct = fun;
        zero = z;
        mem_ready = 1'b1;
        do begin
            #1;
            if (state == 3'd3) begin
                mem_ready = (left == 0);
                if (left > 0) left--;
                #1;
            end
            if (ir_wen) o.irw++;
            if (pc_wen) o.pcw++;
            if (pc_wen && state != 3'd0) o.npc = int'(npc_sel);
            if (RegWrite) begin
                o.rw++;
                o.rdst = int'(RegDst);
                o.wrm = int'(Write_reg_mux);
            end
            if (MemRead) o.mrd++;
            if (Memwrite) o.mwr++;
            if (state == 3'd2) o.alu = int'(alu_op);
            if ((state == 3'd3 || state == 3'd4) && int'(alu_op) != o.alu) o.held_bad++;
            @(posedge clk);
            o.cyc++;
            @(negedge clk);
        end while (state != 3'd0 && state != 3'd5 && o.cyc < 50);
    endtask

    task automatic check_instr(input string tag, input vec_t v);
        obs_t o;
        run_instr(v.opc, v.fun, v.z, v.stalls, o);
        chk({tag, ".cycles"}, o.cyc, v.cyc);
        chk({tag, ".alu_op"}, o.alu, v.alu);
        chk({tag, ".regwrite"}, o.rw, v.rw);
        chk({tag, ".regdst"}, o.rdst, v.rdst);
        chk({tag, ".wr_mux"}, o.wrm, v.wrm);
        chk({tag, ".pc_wen"}, o.pcw, v.pcw);
        chk({tag, ".npc_sel"}, o.npc, v.npc);
        chk({tag, ".memread"}, o.mrd, v.mrd);
        chk({tag, ".memwrite"}, o.mwr, v.mwr);
        chk({tag, ".ir_wen"}, o.irw, 1);
        chk({tag, ".alu_held"}, o.held_bad, 0);
    endtask

    // Cost model: classes 0-4 R-type, 5 addiu, 6 ori, 7 lui, 8 lw, 9 sw, 10 beq, 11 j.
    function automatic vec_t model(input int cls, input logic z, input int stalls,
                                   input logic [5:0] rnd_funct);
        vec_t v;
        logic [5:0] r_functs [5];
        r_functs = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
        v = '{opc: 6'd0, fun: rnd_funct, z: z, stalls: stalls, cyc: 4, alu: 0, rw: 0,
              rdst: 0, wrm: 0, pcw: 1, npc: 3, mrd: 0, mwr: 0};
        if (cls <= 4) begin
            v.fun = r_functs[cls]; v.alu = cls; v.rw = 1; v.rdst = 1;
        end else begin
            case (cls)
                5:  begin v.opc = 6'b001001; v.rw = 1; end
                6:  begin v.opc = 6'b001101; v.rw = 1; v.alu = 3; end
                7:  begin v.opc = 6'b001111; v.rw = 1; v.alu = 5; end
                8:  begin v.opc = 6'b100011; v.rw = 1; v.wrm = 1;
                          v.cyc = 5 + stalls; v.mrd = stalls + 1; end
                9:  begin v.opc = 6'b101011; v.cyc = 4 + stalls; v.mwr = stalls + 1; end
                10: begin v.opc = 6'b000100; v.cyc = 3; v.alu = 1;
                          v.pcw = z ? 2 : 1; v.npc = z ? 1 : 3; end
                default: begin v.opc = 6'b000010; v.cyc = 2; v.alu = 7; v.pcw = 2; v.npc = 2; end
            endcase
        end
        return v;
    endfunction

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t tbl [15];
    int   seq_exp [5];
    obs_t o;

    initial begin
        tbl = '{
            '{6'b000000, 6'b100001, 1'b0, 0, 4, 0, 1, 1, 0, 1, 3, 0, 0},
            '{6'b000000, 6'b100011, 1'b0, 0, 4, 1, 1, 1, 0, 1, 3, 0, 0},
            '{6'b000000, 6'b100100, 1'b0, 0, 4, 2, 1, 1, 0, 1, 3, 0, 0},
            '{6'b000000, 6'b100101, 1'b0, 0, 4, 3, 1, 1, 0, 1, 3, 0, 0},
            '{6'b000000, 6'b101010, 1'b0, 0, 4, 4, 1, 1, 0, 1, 3, 0, 0},
            '{6'b001001, 6'b000000, 1'b0, 0, 4, 0, 1, 0, 0, 1, 3, 0, 0},
            '{6'b001101, 6'b111111, 1'b0, 0, 4, 3, 1, 0, 0, 1, 3, 0, 0},
            '{6'b001111, 6'b000000, 1'b0, 0, 4, 5, 1, 0, 0, 1, 3, 0, 0},
            '{6'b100011, 6'b000000, 1'b0, 0, 5, 0, 1, 0, 1, 1, 3, 1, 0},
            '{6'b100011, 6'b000000, 1'b0, 3, 8, 0, 1, 0, 1, 1, 3, 4, 0},
            '{6'b101011, 6'b000000, 1'b0, 0, 4, 0, 0, 0, 0, 1, 3, 0, 1},
            '{6'b101011, 6'b000000, 1'b0, 2, 6, 0, 0, 0, 0, 1, 3, 0, 3},
            '{6'b000100, 6'b000000, 1'b1, 0, 3, 1, 0, 0, 0, 2, 1, 0, 0},
            '{6'b000100, 6'b000000, 1'b0, 0, 3, 1, 0, 0, 0, 1, 3, 0, 0},
            '{6'b000010, 6'b000000, 1'b0, 0, 2, 7, 0, 0, 0, 2, 2, 0, 0}
        };
        rst = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_ready = 1'b1;

        #12;
        chk("reset.state", int'(state), 0);
        chk("reset.illegal", int'(illegal), 0);
        chk("reset.ir_wen", int'(ir_wen), 0);
        chk("reset.pc_wen", int'(pc_wen), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release.ir_wen", int'(ir_wen), 1);

        // addu state walk 0,1,2,4,0
        seq_exp = '{0, 1, 2, 4, 0};
        opcode = 6'b000000;
        funct = 6'b100001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("addu.state%0d", i), int'(state), seq_exp[i]);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        pulse_reset();

        for (int i = 0; i < 15; i++) begin
            check_instr($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 40; i++) begin
            int cls;
            int st;
            logic z;
            logic [5:0] rf;
            cls = int'($urandom_range(11, 0));
            st = int'($urandom_range(3, 0));
            z = 1'($urandom);
            rf = 6'($urandom);
            check_instr($sformatf("rnd%0d", i), model(cls, z, st, rf));
        end

        // unsupported opcode traps in HALT until reset
        run_instr(6'b111111, 6'd0, 1'b0, 0, o);
        chk("halt.state", int'(state), 5);
        chk("halt.illegal", int'(illegal), 1);
        chk("halt.ir_wen", int'(ir_wen), 0);
        chk("halt.pc_wen", int'(pc_wen), 0);
        repeat (10) @(negedge clk);
        chk("halt.stay_state", int'(state), 5);
        chk("halt.stay_illegal", int'(illegal), 1);
        rst = 1'b0;
        #1;
        chk("halt.rst_illegal", int'(illegal), 0);
        chk("halt.rst_state", int'(state), 0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("halt.resume_fetch", int'(state), 1);
        @(negedge clk);
        pulse_reset();

        // R-type with unknown funct also traps
        run_instr(6'b000000, 6'b000000, 1'b0, 0, o);
        chk("badfunct.state", int'(state), 5);
        chk("badfunct.illegal", int'(illegal), 1);
        pulse_reset();

        // reset mid-MEM on sw drops Memwrite without a clock edge
        opcode = 6'b101011;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("sw_rst.in_mem", int'(state), 3);
        chk("sw_rst.memwrite_before", int'(Memwrite), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("sw_rst.memwrite", int'(Memwrite), 0);
        chk("sw_rst.state", int'(state), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;

        // reset in WB of lw aborts the register write
        opcode = 6'b100011;
        repeat (4) @(negedge clk);
        chk("lw_rst.in_wb", int'(state), 4);
        chk("lw_rst.regwrite_before", int'(RegWrite), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("lw_rst.regwrite", int'(RegWrite), 0);
        chk("lw_rst.state", int'(state), 0);
        @(negedge clk);
        rst = 1'b1;
        check_instr("post_rst", tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
